// File: rtl/call_stack_pkg.sv
// Shared types and defaults for the call/return stack.
package call_stack_pkg;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stack_op_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;

  function automatic stack_op_t decode_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   decode_op = OP_PUSH;
      2'b01:   decode_op = OP_POP;
      2'b11:   decode_op = OP_REPLACE;
      default: decode_op = OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/stack_ptr_ctrl.sv
// Next-pointer, write-enable/index and error-pulse decode for the stack.
module stack_ptr_ctrl
  import call_stack_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  stack_op_t        op,
  input  logic             flush,
  input  logic [CNT_W-1:0] sp,
  output logic [CNT_W-1:0] sp_next,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic             ovf_set,
  output logic             udf_set
);

  logic             is_empty;
  logic             is_full;
  logic [CNT_W-1:0] sp_inc;
  logic [CNT_W-1:0] sp_dec;

  assign is_empty = (sp == '0);
  assign is_full  = (sp == CNT_W'(DEPTH));
  assign sp_inc   = sp + CNT_W'(1);
  assign sp_dec   = sp - CNT_W'(1);

  always_comb begin
    sp_next = sp;
    wr_en   = 1'b0;
    wr_idx  = sp[IDX_W-1:0];
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (flush) begin
      sp_next = '0;
    end else begin
      case (op)
        OP_PUSH: begin
          if (is_full) begin
            ovf_set = 1'b1;
          end else begin
            wr_en   = 1'b1;
            sp_next = sp_inc;
          end
        end
        OP_POP: begin
          if (is_empty) udf_set = 1'b1;
          else          sp_next = sp_dec;
        end
        OP_REPLACE: begin
          // On an empty stack there is no top to replace, so it degrades to a push.
          wr_en = 1'b1;
          if (is_empty) sp_next = sp_inc;
          else          wr_idx  = sp[IDX_W-1:0] - IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/call_stack_unit.sv
// Parametrised LIFO for CALL/RET and PUSH/POP; sticky error flags exist only
// when CALL_STACK_ERR_EN is defined.
module call_stack_unit
  import call_stack_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  input  logic              err_clr,
  output logic [DATA_W-1:0] top_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  sp;
  logic [CNT_W-1:0]  sp_next;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic              ovf_set;
  logic              udf_set;
  logic [IDX_W-1:0]  top_idx;
  stack_op_t         op;

  assign op = decode_op(push, pop);

  stack_ptr_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_ctrl (
    .op      (op),
    .flush   (flush),
    .sp      (sp),
    .sp_next (sp_next),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .ovf_set (ovf_set),
    .udf_set (udf_set)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sp <= '0;
    else       sp <= sp_next;
  end

  // Array is data only: never reset, writes suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_idx] <= push_data;
  end

`ifdef CALL_STACK_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow  & ~err_clr);
      underflow <= udf_set | (underflow & ~err_clr);
    end
  end
`else
  logic unused_err;
  assign unused_err = &{1'b0, err_clr, ovf_set, udf_set};
  assign overflow   = 1'b0;
  assign underflow  = 1'b0;
`endif

  assign top_idx  = sp[IDX_W-1:0] - IDX_W'(1);
  assign count    = sp;
  assign empty    = (sp == '0);
  assign full     = (sp == CNT_W'(DEPTH));
  assign top_data = empty ? '0 : mem[top_idx];

endmodule

// File: tb/tb_call_stack_unit.sv
// Directed bench for call_stack_unit: a DEPTH=16 and a DEPTH=4 instance.
module tb_call_stack_unit;

`ifdef CALL_STACK_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic        a_flush = 0, a_push = 0, a_pop = 0, a_err_clr = 0;
  logic [31:0] a_data = '0;
  logic [31:0] a_top;
  logic [4:0]  a_count;
  logic        a_empty, a_full, a_ovf, a_udf;

  logic        b_flush = 0, b_push = 0, b_pop = 0, b_err_clr = 0;
  logic [31:0] b_data = '0;
  logic [31:0] b_top;
  logic [2:0]  b_count;
  logic        b_empty, b_full, b_ovf, b_udf;

  always #5 clk = ~clk;

  call_stack_unit #(.DATA_W(32), .DEPTH(16)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush), .push(a_push), .pop(a_pop),
    .push_data(a_data), .err_clr(a_err_clr), .top_data(a_top), .count(a_count),
    .empty(a_empty), .full(a_full), .overflow(a_ovf), .underflow(a_udf)
  );

  call_stack_unit #(.DATA_W(32), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush), .push(b_push), .pop(b_pop),
    .push_data(b_data), .err_clr(b_err_clr), .top_data(b_top), .count(b_count),
    .empty(b_empty), .full(b_full), .overflow(b_ovf), .underflow(b_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_a(input logic ps, input logic pp, input logic fl,
                       input logic ec, input logic [31:0] d);
    a_push = ps; a_pop = pp; a_flush = fl; a_err_clr = ec; a_data = d;
    @(posedge clk); #1;
    a_push = 0; a_pop = 0; a_flush = 0; a_err_clr = 0;
  endtask

  task automatic run_b(input logic ps, input logic pp, input logic fl,
                       input logic ec, input logic [31:0] d);
    b_push = ps; b_pop = pp; b_flush = fl; b_err_clr = ec; b_data = d;
    @(posedge clk); #1;
    b_push = 0; b_pop = 0; b_flush = 0; b_err_clr = 0;
  endtask

  initial begin
    #23 reset = 1'b0;
    chk("rst_count", 32'(a_count), 0);
    chk("rst_empty", 32'(a_empty), 1);
    chk("rst_full",  32'(a_full),  0);
    chk("rst_top",   a_top,        0);
    chk("rst_ovf",   32'(a_ovf),   0);
    chk("rst_udf",   32'(a_udf),   0);
    chk("rst_b_empty", 32'(b_empty), 1);

    run_a(1, 0, 0, 0, 32'h11);
    run_a(1, 0, 0, 0, 32'h22);
    run_a(1, 0, 0, 0, 32'h33);
    chk("push3_count", 32'(a_count), 3);
    chk("push3_top",   a_top,        32'h33);
    chk("push3_empty", 32'(a_empty), 0);
    run_a(0, 1, 0, 0, 0);
    chk("pop_top",   a_top,        32'h22);
    chk("pop_count", 32'(a_count), 2);

    run_a(1, 1, 0, 0, 32'h99);
    chk("repl_top",   a_top,        32'h99);
    chk("repl_count", 32'(a_count), 2);

    run_a(1, 0, 0, 0, 32'h44);
    chk("push4_count", 32'(a_count), 3);
    run_a(1, 0, 1, 0, 32'h77);
    chk("flush_count", 32'(a_count), 0);
    chk("flush_empty", 32'(a_empty), 1);
    chk("flush_top",   a_top,        0);
    run_a(1, 0, 0, 0, 32'h55);
    chk("aflush_top",   a_top,        32'h55);
    chk("aflush_count", 32'(a_count), 1);
    run_a(1, 0, 0, 0, 32'h66);
    chk("pre_rst_count", 32'(a_count), 2);

    #3 reset = 1'b1;
    #1;
    chk("async_count", 32'(a_count), 0);
    chk("async_empty", 32'(a_empty), 1);
    chk("async_top",   a_top,        0);
    run_a(1, 0, 0, 0, 32'hEE);
    chk("rst_push_ignored", 32'(a_count), 0);
    reset = 1'b0;

    run_a(0, 1, 0, 0, 0);
    chk("udf_set",   32'(a_udf),   32'(ERR));
    chk("udf_count", 32'(a_count), 0);
    run_a(0, 0, 0, 1, 0);
    chk("udf_clr", 32'(a_udf), 0);
    run_a(1, 1, 0, 0, 32'h5A);
    chk("repl_empty_count", 32'(a_count), 1);
    chk("repl_empty_top",   a_top,        32'h5A);
    chk("repl_empty_udf",   32'(a_udf),   0);
    run_a(0, 1, 0, 0, 0);
    run_a(0, 1, 0, 0, 0);
    chk("udf_again", 32'(a_udf), 32'(ERR));
    run_a(0, 1, 0, 1, 0);
    chk("udf_set_wins", 32'(a_udf), 32'(ERR));
    run_a(0, 0, 0, 1, 0);
    chk("udf_clr2", 32'(a_udf), 0);
    chk("a_ovf_quiet", 32'(a_ovf), 0);

    run_b(1, 0, 0, 0, 32'hA0);
    run_b(1, 0, 0, 0, 32'hA1);
    run_b(1, 0, 0, 0, 32'hA2);
    chk("b3_full", 32'(b_full), 0);
    run_b(1, 0, 0, 0, 32'hA3);
    chk("b4_full",  32'(b_full),  1);
    chk("b4_count", 32'(b_count), 4);
    chk("b4_top",   b_top,        32'hA3);
    chk("b4_ovf",   32'(b_ovf),   0);
    run_b(1, 0, 0, 0, 32'hA4);
    chk("b5_ovf",   32'(b_ovf),   32'(ERR));
    chk("b5_top",   b_top,        32'hA3);
    chk("b5_count", 32'(b_count), 4);
    run_b(0, 0, 0, 1, 0);
    chk("b_ovf_clr", 32'(b_ovf), 0);
    run_b(1, 1, 0, 0, 32'hBB);
    chk("b_repl_full_top",   b_top,        32'hBB);
    chk("b_repl_full_count", 32'(b_count), 4);
    chk("b_repl_full_ovf",   32'(b_ovf),   0);
    run_b(0, 1, 0, 0, 0);
    chk("b_pop_top", b_top, 32'hA2);
    run_b(1, 0, 0, 0, 32'hCC);
    run_b(1, 0, 0, 0, 32'hDD);
    chk("b_ovf_again", 32'(b_ovf), 32'(ERR));
    run_b(0, 0, 1, 0, 0);
    chk("b_flush_count", 32'(b_count), 0);
    chk("b_flush_keeps_ovf", 32'(b_ovf), 32'(ERR));
    chk("b_udf_quiet", 32'(b_udf), 0);
    chk("b_flush_top", b_top, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
